// File: rtl/matrix_pkg.sv
// Shared types for the matrix sequencer: controller states and read address-space selects.
package matrix_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MATRIX,
    LOAD_VECTOR,
    PROCESS,
    START_DIV,
    WAIT_DIV,
    NORMALIZE
  } state_e;

  localparam logic RD_SEL_MATRIX = 1'b0;
  localparam logic RD_SEL_VECTOR = 1'b1;

endpackage

// File: rtl/seq_index_counter.sv
// Element index counter with synchronous clear (priority over enable) and a
// terminal-count flag compared against a runtime limit.
module seq_index_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] idx_o,
  output logic         tc_o
);

  logic [W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = idx_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;
  assign tc_o  = (idx_q == limit_i);

endmodule

// File: rtl/matrix_sequencer_gen2.sv
// Batch controller for the matrix datapath: matrix/vector load, MAC sweep,
// optional perspective divide and coordinate write-out per work item.
module matrix_sequencer_gen2
  import matrix_pkg::*;
#(
  parameter int  DIM    = 4,
  parameter int  COORDS = 3,
  parameter int  WI_W   = 16,
  localparam int IDX_W  = $clog2(DIM*DIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WI_W-1:0]  work_items_i,
  input  logic             reuse_matrix_i,
  input  logic             persp_en_i,
  input  logic             rd_valid_i,
  input  logic             wr_ready_i,
  input  logic             div_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             rd_req_o,
  output logic             rd_sel_o,
  output logic             load_matrix_o,
  output logic             load_vector_o,
  output logic             fma_en_o,
  output logic             acc_wr_en_o,
  output logic             start_div_o,
  output logic             scale_en_o,
  output logic             wr_en_o,
  output logic [WI_W-1:0]  wi_remaining_o,
  output state_e           state_o
);

  localparam int LOG2_DIM = $clog2(DIM);

  state_e           state_q;
  logic [WI_W-1:0]  wi_rem_q;
  logic             matrix_valid_q, persp_q, done_q;
  logic [IDX_W-1:0] cnt_idx, cnt_limit;
  logic             cnt_tc, advance, last, cnt_clr;

  // Handshake: an element is accepted in a cycle only when the phase's
  // qualifier (rd_valid in loads, always in PROCESS, wr_ready in NORMALIZE) is high.
  always_comb begin
    cnt_limit = '0;
    advance   = 1'b0;
    case (state_q)
      LOAD_MATRIX: begin cnt_limit = IDX_W'(DIM*DIM-1); advance = rd_valid_i; end
      LOAD_VECTOR: begin cnt_limit = IDX_W'(DIM-1);     advance = rd_valid_i; end
      PROCESS:     begin cnt_limit = IDX_W'(DIM*DIM-1); advance = 1'b1;       end
      NORMALIZE:   begin cnt_limit = IDX_W'(COORDS-1);  advance = wr_ready_i; end
      default:     ;
    endcase
  end

  assign last    = advance & cnt_tc;
  assign cnt_clr = last | (state_q == IDLE) | (state_q == START_DIV) | (state_q == WAIT_DIV);

  seq_index_counter #(.W(IDX_W)) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (advance),
    .limit_i (cnt_limit),
    .idx_o   (cnt_idx),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      wi_rem_q       <= '0;
      matrix_valid_q <= 1'b0;
      persp_q        <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          wi_rem_q <= work_items_i;
          persp_q  <= persp_en_i;
          if (work_items_i == '0) begin
            done_q <= 1'b1;
          end else if (reuse_matrix_i && matrix_valid_q) begin
            state_q <= LOAD_VECTOR;
          end else begin
            state_q <= LOAD_MATRIX;
          end
        end
        LOAD_MATRIX: if (last) begin
          matrix_valid_q <= 1'b1;
          state_q        <= LOAD_VECTOR;
        end
        LOAD_VECTOR: if (last) state_q <= PROCESS;
        PROCESS:     if (last) state_q <= persp_q ? START_DIV : NORMALIZE;
        START_DIV:   state_q <= WAIT_DIV;
        WAIT_DIV:    if (div_done_i) state_q <= NORMALIZE;
        NORMALIZE: if (last) begin
          wi_rem_q <= wi_rem_q - WI_W'(1);
          if (wi_rem_q == WI_W'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= LOAD_VECTOR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign idx_o          = cnt_idx;
  assign rd_req_o       = (state_q == LOAD_MATRIX) | (state_q == LOAD_VECTOR);
  assign rd_sel_o       = (state_q == LOAD_VECTOR) ? RD_SEL_VECTOR : RD_SEL_MATRIX;
  assign load_matrix_o  = (state_q == LOAD_MATRIX) & rd_valid_i;
  assign load_vector_o  = (state_q == LOAD_VECTOR) & rd_valid_i;
  assign fma_en_o       = (state_q == PROCESS);
  assign acc_wr_en_o    = (state_q == PROCESS) && (cnt_idx[LOG2_DIM-1:0] == LOG2_DIM'(DIM-1));
  assign start_div_o    = (state_q == START_DIV);
  assign scale_en_o     = (state_q == NORMALIZE) & persp_q;
  assign wr_en_o        = (state_q == NORMALIZE);
  assign wi_remaining_o = wi_rem_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_matrix_sequencer_gen2.sv
// Bench for matrix_sequencer_gen2: phase-plan reference model checked every cycle,
// plus directed scenarios pinned with hand-computed strobe counts.
module tb_matrix_sequencer_gen2;
  localparam int DIM = 4, COORDS = 3, WI_W = 16, IDX_W = 4;
  localparam int K_IDLE = 0, K_LM = 1, K_LV = 2, K_PR = 3, K_SD = 4, K_WD = 5, K_NO = 6;
  localparam int C_LM = 0, C_LV = 1, C_FMA = 2, C_ACC = 3, C_SD = 4, C_WRA = 5, C_WRC = 6,
                 C_SCL = 7, C_DONE = 8, C_BUSY = 9;

  // clock / reset
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic            start = 0, reuse = 0, persp = 0, rd_valid = 1, wr_ready = 1, div_done = 0;
  logic [WI_W-1:0] work_items = '0;
  logic            busy, done, rd_req, rd_sel, load_matrix, load_vector, fma_en, acc_wr_en;
  logic            start_div, scale_en, wr_en;
  logic [IDX_W-1:0] idx;
  logic [WI_W-1:0] wi_remaining;
  matrix_pkg::state_e dut_state;

  matrix_sequencer_gen2 #(.DIM(DIM), .COORDS(COORDS), .WI_W(WI_W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .work_items_i(work_items),
    .reuse_matrix_i(reuse), .persp_en_i(persp), .rd_valid_i(rd_valid),
    .wr_ready_i(wr_ready), .div_done_i(div_done), .busy_o(busy), .done_o(done),
    .idx_o(idx), .rd_req_o(rd_req), .rd_sel_o(rd_sel), .load_matrix_o(load_matrix),
    .load_vector_o(load_vector), .fma_en_o(fma_en), .acc_wr_en_o(acc_wr_en),
    .start_div_o(start_div), .scale_en_o(scale_en), .wr_en_o(wr_en),
    .wi_remaining_o(wi_remaining), .state_o(dut_state)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a batch expands into a list of phases
  typedef struct { int kind; int len; } phase_t;
  phase_t plan_q[$];
  int m_kind = K_IDLE, m_len = 0, m_cnt = 0, m_wi = 0;
  bit m_mv = 0, m_persp = 0, m_done = 0;

  task automatic model_reset();
    plan_q.delete();
    m_kind = K_IDLE; m_len = 0; m_cnt = 0; m_wi = 0; m_mv = 0; m_persp = 0; m_done = 0;
  endtask

  task automatic next_phase();
    phase_t p;
    p = plan_q.pop_front();
    m_kind = p.kind; m_len = p.len; m_cnt = 0;
  endtask

  function automatic bit bump();
    if (m_cnt == m_len - 1) begin m_cnt = 0; return 1'b1; end
    m_cnt++;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit complete = 0;
    m_done = 0;
    case (m_kind)
      K_IDLE: if (start) begin
        if (work_items == 0) m_done = 1;
        else begin
          if (!(reuse && m_mv)) plan_q.push_back('{K_LM, DIM*DIM});
          for (int i = 0; i < int'(work_items); i++) begin
            plan_q.push_back('{K_LV, DIM});
            plan_q.push_back('{K_PR, DIM*DIM});
            if (persp) begin
              plan_q.push_back('{K_SD, 1});
              plan_q.push_back('{K_WD, 1});
            end
            plan_q.push_back('{K_NO, COORDS});
          end
          m_wi = int'(work_items); m_persp = persp;
          next_phase();
        end
      end
      K_LM, K_LV: if (rd_valid) complete = bump();
      K_PR: complete = bump();
      K_SD: complete = 1;
      K_WD: complete = div_done;
      K_NO: if (wr_ready) begin complete = bump(); if (complete) m_wi--; end
      default: ;
    endcase
    if (complete) begin
      if (m_kind == K_LM) m_mv = 1;
      if (plan_q.size() == 0) begin m_kind = K_IDLE; m_len = 0; m_cnt = 0; m_done = 1; end
      else next_phase();
    end
  endtask

  // scoreboard: compare every cycle on the falling edge, then advance the model
  logic [30:0] exp_v, act_v;
  always @(negedge clk) begin
    if (rst) model_reset();
    exp_v = {m_kind != K_IDLE, m_done, 4'(m_cnt), (m_kind == K_LM || m_kind == K_LV),
             m_kind == K_LV, (m_kind == K_LM) && rd_valid, (m_kind == K_LV) && rd_valid,
             m_kind == K_PR, (m_kind == K_PR) && (m_cnt % DIM == DIM - 1), m_kind == K_SD,
             (m_kind == K_NO) && m_persp, m_kind == K_NO, 16'(m_wi)};
    act_v = {busy, done, idx, rd_req, rd_sel, load_matrix, load_vector, fma_en, acc_wr_en,
             start_div, scale_en, wr_en, wi_remaining};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      if (failures <= 30)
        $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act_v, exp_v);
    end
    if (!rst) model_step();
  end

  // event counters and traces observed from the DUT
  int cnt[10] = '{default: 0};
  int base[10];
  bit seen_rd = 0, first_rd_sel = 0;
  logic [WI_W-1:0] wi_trace[$];
  logic [WI_W-1:0] last_wi = '0;
  always @(negedge clk) begin
    cnt[C_LM] += int'(load_matrix); cnt[C_LV] += int'(load_vector);
    cnt[C_FMA] += int'(fma_en);     cnt[C_ACC] += int'(acc_wr_en);
    cnt[C_SD] += int'(start_div);   cnt[C_WRA] += int'(wr_en && wr_ready);
    cnt[C_WRC] += int'(wr_en);      cnt[C_SCL] += int'(scale_en && wr_en && wr_ready);
    cnt[C_DONE] += int'(done);      cnt[C_BUSY] += int'(busy);
    if (start) seen_rd = 0;
    else if (rd_req && !seen_rd) begin seen_rd = 1; first_rd_sel = rd_sel; end
    if (wi_remaining !== last_wi) begin wi_trace.push_back(wi_remaining); last_wi = wi_remaining; end
  end

  // input driver: read data, write acceptance and divider response
  bit rv_rand = 0, wr_rand = 0, div_rand = 0, stall_arm = 0;
  int div_cnt = 0, stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (div_rand) div_done = ($urandom_range(0, 3) == 0);
    else begin
      div_done = 0;
      if (div_cnt > 0) begin div_cnt--; if (div_cnt == 0) div_done = 1; end
      if (start_div) div_cnt = 3;
    end
    rd_valid = rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stall_cnt > 0) begin wr_ready = 0; stall_cnt--; end
    else if (stall_arm && wr_en && idx == 4'd1) begin stall_arm = 0; stall_cnt = 4; wr_ready = 0; end
    else wr_ready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic int d(input int i);
    return cnt[i] - base[i];
  endfunction

  task automatic snap();
    for (int i = 0; i < 10; i++) base[i] = cnt[i];
  endtask

  task automatic do_start(input int wi, input bit re, input bit pe);
    @(posedge clk); #1;
    start = 1; work_items = WI_W'(wi); reuse = re; persp = pe;
    @(posedge clk); #1;
    start = 0; work_items = WI_W'($urandom); reuse = 1'($urandom); persp = 1'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (done) got = 1;
    end
    if (!got) check({name, "_timeout"}, 0, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic run_batch(input string name, input int wi, input bit re, input bit pe,
                           input bit poke_busy);
    snap();
    do_start(wi, re, pe);
    if (poke_busy) begin
      repeat (3) @(posedge clk);
      #1 start = 1; work_items = 16'd5;
      @(posedge clk); #1 start = 0;
    end
    wait_done(name, 3000);
  endtask

  int tb0;
  bit hit;
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_idx", idx, 0);
    check("reset_wi_remaining", wi_remaining, 0);
    check("reset_done", done, 0);
    @(posedge clk); #1 rst = 0;

    // single item with perspective divide
    run_batch("b1", 1, 0, 1, 0);
    check("b1_load_matrix", d(C_LM), 16);
    check("b1_load_vector", d(C_LV), 4);
    check("b1_fma", d(C_FMA), 16);
    check("b1_acc_wr", d(C_ACC), 4);
    check("b1_start_div", d(C_SD), 1);
    check("b1_wr", d(C_WRA), 3);
    check("b1_scale", d(C_SCL), 3);
    check("b1_done", d(C_DONE), 1);

    // two items, no divide
    tb0 = wi_trace.size();
    run_batch("b2", 2, 0, 0, 0);
    check("b2_load_matrix", d(C_LM), 16);
    check("b2_load_vector", d(C_LV), 8);
    check("b2_start_div", d(C_SD), 0);
    check("b2_wr", d(C_WRA), 6);
    check("b2_scale", d(C_SCL), 0);
    check("b2_wi_trace_len", wi_trace.size() - tb0, 3);
    if (wi_trace.size() - tb0 == 3) begin
      check("b2_wi_trace0", int'(wi_trace[tb0]), 2);
      check("b2_wi_trace1", int'(wi_trace[tb0+1]), 1);
      check("b2_wi_trace2", int'(wi_trace[tb0+2]), 0);
    end

    // resident matrix reuse
    run_batch("b3", 1, 1, 0, 0);
    check("b3_load_matrix", d(C_LM), 0);
    check("b3_first_rd_sel", first_rd_sel, 1);

    // throttled reads and a write stall
    rv_rand = 1; stall_arm = 1;
    run_batch("b4", 2, 1, 1, 0);
    rv_rand = 0;
    check("b4_load_matrix", d(C_LM), 0);
    check("b4_load_vector", d(C_LV), 8);
    check("b4_wr_accepted", d(C_WRA), 6);
    check("b4_wr_cycles", d(C_WRC), 11);
    check("b4_scale", d(C_SCL), 6);
    check("b4_start_div", d(C_SD), 2);

    // empty batch
    snap();
    do_start(0, 0, 0);
    @(negedge clk); #1;
    check("b5_done_next_cycle", done, 1);
    repeat (3) @(posedge clk);
    check("b5_busy_cycles", d(C_BUSY), 0);
    check("b5_done_pulses", d(C_DONE), 1);

    // reset during PROCESS at idx 9
    snap();
    do_start(1, 1, 0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      if (fma_en && idx == 4'd9) hit = 1;
    end
    check("b6_reached_idx9", hit, 1);
    #1 rst = 1;
    #1;
    check("b6_rst_busy", busy, 0);
    check("b6_rst_idx", idx, 0);
    check("b6_rst_fma", fma_en, 0);
    check("b6_rst_wi", wi_remaining, 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    check("b6_no_done", d(C_DONE), 0);
    run_batch("b6b", 1, 1, 0, 0);
    check("b6_reload_matrix", d(C_LM), 16);
    check("b6_first_rd_sel", first_rd_sel, 0);

    // randomized batches, with a start poked while busy
    rv_rand = 1; wr_rand = 1; div_rand = 1;
    for (int n = 0; n < 8; n++) begin
      run_batch("rnd", $urandom_range(1, 3), 1'($urandom), 1'($urandom), 1);
      check("rnd_done_pulses", d(C_DONE), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
